// File: rtl/key_debouncer.sv
// key_debouncer: per-channel key debouncer with press/release edge pulses
// and auto-repeat. Each channel synchronizes its raw key level, requires
// DEBOUNCE_CYCLES consecutive differing samples before accepting a new level,
// and then runs a small UP/DOWN/REPEAT state machine that emits repeat pulses
// while the key stays held.
module key_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 60000,
    parameter int REPEAT_DELAY    = 3000000,
    parameter int REPEAT_RATE     = 600000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] keys_in,
    output logic [WIDTH-1:0] keys_stable,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    output logic [WIDTH-1:0] repeated
);

    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam bit                REPEAT_ON  = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        UP     = 2'd0,
        DOWN   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic              sync_p0;
        logic              sync_p1;
        logic              stable;
        logic [CNT_W-1:0]  cnt;
        logic              differs;
        logic              accept;

        key_state_t        state;
        key_state_t        state_nxt;
        logic [HOLD_W-1:0] hold;
        logic [HOLD_W-1:0] hold_nxt;
        logic              press_nxt;
        logic              rel_nxt;
        logic              rep_nxt;
        logic              press_q;
        logic              rel_q;
        logic              rep_q;

        // Two-flop synchronizer for the asynchronous raw key level.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
            end else begin
                sync_p0 <= keys_in[i];
                sync_p1 <= sync_p0;
            end
        end

        // A new level is accepted on the edge that sees its DEBOUNCE_CYCLES-th consecutive sample.
        always_comb begin
            differs = (sync_p1 != stable);
            accept  = differs && (cnt == CNT_LAST);
        end

        // Debounce counter and accepted level; any agreeing sample restarts the count.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (!differs) begin
                cnt    <= '0;
            end else if (accept) begin
                cnt    <= '0;
                stable <= sync_p1;
            end else begin
                cnt    <= cnt + CNT_ONE;
            end
        end

        // Next state, hold counter and pulse decisions; a release always beats a repeat.
        always_comb begin
            state_nxt = state;
            hold_nxt  = hold;
            press_nxt = accept && sync_p1;
            rel_nxt   = accept && !sync_p1;
            rep_nxt   = 1'b0;
            case (state)
                UP: begin
                    if (press_nxt) begin
                        state_nxt = DOWN;
                        hold_nxt  = '0;
                    end
                end
                DOWN: begin
                    if (rel_nxt) begin
                        state_nxt = UP;
                        hold_nxt  = '0;
                    end else if (REPEAT_ON) begin
                        if (hold == DELAY_LAST) begin
                            state_nxt = REPEAT;
                            hold_nxt  = '0;
                            rep_nxt   = 1'b1;
                        end else begin
                            hold_nxt  = hold + HOLD_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (rel_nxt) begin
                        state_nxt = UP;
                        hold_nxt  = '0;
                    end else if (hold == RATE_LAST) begin
                        hold_nxt  = '0;
                        rep_nxt   = 1'b1;
                    end else begin
                        hold_nxt  = hold + HOLD_ONE;
                    end
                end
                default: begin
                    state_nxt = UP;
                    hold_nxt  = '0;
                end
            endcase
        end

        // State register and registered one-cycle output pulses.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state   <= UP;
                hold    <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                hold    <= hold_nxt;
                press_q <= press_nxt;
                rel_q   <= rel_nxt;
                rep_q   <= rep_nxt;
            end
        end

        assign keys_stable[i] = stable;
        assign pressed[i]     = press_q;
        assign released[i]    = rel_q;
        assign repeated[i]    = rep_q;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer: a timestamp-based reference model feeds a
// scoreboard checked every cycle, a table of stimulus segments with
// hand-derived pulse counts, and directed sequences for timing and reset.
module tb_key_debouncer;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] keys  = 8'h00;

    logic [7:0] st_a, pr_a, rl_a, rp_a;
    logic [7:0] st_b, pr_b, rl_b, rp_b;

    always #5 clk = ~clk;

    key_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_a (
        .clock      (clk),
        .reset      (rst_n),
        .keys_in    (keys),
        .keys_stable(st_a),
        .pressed    (pr_a),
        .released   (rl_a),
        .repeated   (rp_a)
    );

    key_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_RATE(RR)) dut_b (
        .clock      (clk),
        .reset      (rst_n),
        .keys_in    (keys),
        .keys_stable(st_b),
        .pressed    (pr_b),
        .released   (rl_b),
        .repeated   (rp_b)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    typedef struct {
        logic [7:0] k;
        int         n;
        logic [7:0] st;
        int         pr;
        int         rl;
        int         rp;
    } seg_t;

    exp_t       sb[$];
    seg_t       segs[9];
    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    logic [7:0] m_raw  = 8'h00;
    logic [7:0] m_st   = 8'h00;
    int         since[8];
    int         fedge[8];
    int         seg_pr, seg_rl, seg_rp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_raw = 8'h00;
        m_st  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            since[i] = 0;
            fedge[i] = 0;
        end
        sb.delete();
    endfunction

    // Reference: a level held for D+2 sampling edges is accepted on the last
    // of them; repeats fall at RD + k*RR edges after the accepting edge.
    task automatic model_edge(input logic [7:0] k);
        logic [7:0] p;
        logic [7:0] r;
        logic [7:0] q;
        int         age;
        p = 8'h00;
        r = 8'h00;
        q = 8'h00;
        edge_n++;
        for (int i = 0; i < 8; i++) begin
            if (k[i] !== m_raw[i]) begin
                since[i] = edge_n;
                m_raw[i] = k[i];
            end
            if (k[i] !== m_st[i] && (edge_n - since[i] + 1) == D + 2) begin
                m_st[i] = k[i];
                if (k[i]) begin
                    p[i]     = 1'b1;
                    fedge[i] = edge_n;
                end else begin
                    r[i] = 1'b1;
                end
            end else if (m_st[i]) begin
                age = edge_n - fedge[i];
                if (age >= RD && ((age - RD) % RR) == 0) q[i] = 1'b1;
            end
        end
        sb.push_back('{a: {m_st, p, r, q}, b: {m_st, p, r, 8'h00}});
    endtask

    task automatic step(input logic [7:0] k);
        exp_t e;
        keys = k;
        @(posedge clk);
        model_edge(k);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no expected entry at time %0t", $time);
        end else begin
            e = sb.pop_front();
            check("sb_a", {st_a, pr_a, rl_a, rp_a}, e.a);
            check("sb_b", {st_b, pr_b, rl_b, rp_b}, e.b);
            check("exclusive", 32'((pr_a & rl_a) | (pr_a & rp_a) | (rl_a & rp_a)), 32'h0);
        end
        seg_pr += $countones(pr_a);
        seg_rl += $countones(rl_a);
        seg_rp += $countones(rp_a);
    endtask

    // Asserts reset between clock edges and expects every output cleared at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_a", {st_a, pr_a, rl_a, rp_a}, 32'h0);
        check("rst_async_b", {st_b, pr_b, rl_b, rp_b}, 32'h0);
        @(negedge clk);
        check("rst_hold_a", {st_a, pr_a, rl_a, rp_a}, 32'h0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rep_q[$];
        int rel_n;
        int late_rep;
        int rep_n;
        int b_rep;
        bit seen;

        segs[0] = '{8'h00,  5, 8'h00, 0, 0, 0};
        segs[1] = '{8'h01,  8, 8'h01, 1, 0, 0};
        segs[2] = '{8'h01, 20, 8'h01, 0, 0, 5};
        segs[3] = '{8'h00,  3, 8'h01, 0, 0, 1};
        segs[4] = '{8'h01, 10, 8'h01, 0, 0, 3};
        segs[5] = '{8'h00,  8, 8'h00, 0, 1, 2};
        segs[6] = '{8'h81,  8, 8'h81, 2, 0, 0};
        segs[7] = '{8'h01,  8, 8'h01, 0, 1, 1};
        segs[8] = '{8'h00,  8, 8'h00, 0, 1, 1};

        model_reset();
        do_reset();

        // press timing and repeat cadence on key 0
        for (int s = 1; s <= 22; s++) begin
            step(8'h01);
            if (s == 5) check("press_early", 32'(st_a), 32'h00);
            if (s == 6) check("press_edge", 32'({st_a, pr_a}), 32'h0101);
            if (s == 7) check("press_once", 32'(pr_a), 32'h00);
            if (rp_a[0]) rep_q.push_back(s);
        end
        check("rep_count", 32'(rep_q.size()), 32'd3);
        if (rep_q.size() == 3) begin
            check("rep_first", 32'(rep_q[0]), 32'd16);
            check("rep_second", 32'(rep_q[1]), 32'd19);
            check("rep_third", 32'(rep_q[2]), 32'd22);
        end

        // release: one released pulse, nothing repeats from then on
        rel_n    = 0;
        late_rep = 0;
        seen     = 1'b0;
        for (int s = 1; s <= 16; s++) begin
            step(8'h00);
            if (rl_a[0]) seen = 1'b1;
            if (seen && rp_a[0]) late_rep++;
            rel_n += int'(rl_a[0]);
        end
        check("release_count", 32'(rel_n), 32'd1);
        check("late_repeat", 32'(late_rep), 32'd0);
        check("release_level", 32'(st_a), 32'h00);

        // segment table from a clean reset
        do_reset();
        for (int s = 0; s < 9; s++) begin
            seg_pr = 0;
            seg_rl = 0;
            seg_rp = 0;
            for (int c = 0; c < segs[s].n; c++) step(segs[s].k);
            check($sformatf("seg%0d_stable", s), 32'(st_a), 32'(segs[s].st));
            check($sformatf("seg%0d_press", s), 32'(seg_pr), 32'(segs[s].pr));
            check($sformatf("seg%0d_release", s), 32'(seg_rl), 32'(segs[s].rl));
            check($sformatf("seg%0d_repeat", s), 32'(seg_rp), 32'(segs[s].rp));
        end

        // reset in the middle of auto-repeat, key kept held
        rep_n = 0;
        for (int s = 1; s <= 20; s++) begin
            step(8'h01);
            rep_n += int'(rp_a[0]);
        end
        check("midrep_reps", 32'(rep_n), 32'd2);
        do_reset();
        for (int s = 1; s <= 6; s++) begin
            step(8'h01);
            if (s == 5) check("rearm_early", 32'({st_a, pr_a}), 32'h0000);
            if (s == 6) check("rearm_press", 32'(pr_a), 32'h01);
        end

        // auto-repeat disabled instance with the key held
        b_rep = 0;
        for (int s = 1; s <= 100; s++) begin
            step(8'h01);
            b_rep += $countones(rp_b);
        end
        check("norepeat_b", 32'(b_rep), 32'd0);
        check("norepeat_b_level", 32'(st_b), 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
